// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the X/M memory stage and a single-word data-memory port.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   x_dm_*                   core request in X (held stable while stalled)
//   flush_i                  invalidate all lines (applied when idle)
//   m_dm_dout_o              registered load data for M
//   dcache_stall_o           combinational pipeline stall
//   dm_* / dm_busy_i ...     memory request port with busy / rvalid handshake
//   load_cnt_o, miss_cnt_o   saturating performance counters
module dcache_dm #(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 x_dm_en_i,
    input  logic                 x_dm_wen_i,
    input  logic [31:0]          x_dm_addr_i,
    input  logic [31:0]          x_dm_din_i,
    input  logic [3:0]           x_dm_be_i,
    input  logic                 flush_i,
    output logic [31:0]          m_dm_dout_o,
    output logic                 dcache_stall_o,
    output logic                 dm_en_o,
    output logic                 dm_wen_o,
    output logic [31:0]          dm_addr_o,
    output logic [31:0]          dm_din_o,
    output logic [3:0]           dm_be_o,
    input  logic                 dm_busy_i,
    input  logic                 dm_rvalid_i,
    input  logic [31:0]          dm_dout_i,
    output logic [CNT_WIDTH-1:0] load_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o
);

    localparam int unsigned OFF   = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX   = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - OFF - IDX;
    localparam int unsigned CW    = (OFF > 0) ? OFF : 1;
    // Flat word index {index, offset} into the data array; exact power of two.
    localparam int unsigned AW    = IDX + OFF;

    typedef enum logic [2:0] {
        IDLE,
        REFILL_REQ,
        REFILL_WAIT,
        WRITE,
        WDONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      data_q [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic             flush_pending_q;
    logic [CW-1:0]    cnt_q;

    logic [IDX-1:0]   req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      line_base;
    logic [AW-1:0]    word_idx;
    logic [AW-1:0]    fill_idx;
    logic             hit;
    logic             refill_last;

    logic stall;
    logic load_hit, miss_start, flush_apply, refill_beat, store_merge;

    // Address decomposition; shifts keep the zero-width offset case legal.
    assign req_idx     = IDX'(x_dm_addr_i >> (2 + OFF));
    assign req_tag     = TAG_W'(x_dm_addr_i >> (2 + OFF + IDX));
    assign line_base   = (x_dm_addr_i >> (2 + OFF)) << (2 + OFF);
    assign word_idx    = AW'(x_dm_addr_i >> 2);
    assign fill_idx    = AW'((line_base >> 2) | 32'(cnt_q));
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign refill_last = (cnt_q == CW'(WORDS_PER_LINE - 1));

    // Next-state, memory port and event strobes.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        dm_en_o     = 1'b0;
        dm_wen_o    = 1'b0;
        dm_addr_o   = '0;
        dm_din_o    = '0;
        dm_be_o     = '0;
        load_hit    = 1'b0;
        miss_start  = 1'b0;
        flush_apply = 1'b0;
        refill_beat = 1'b0;
        store_merge = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_pending_q) begin
                    // Flush wins; a waiting request is looked up next cycle.
                    flush_apply = 1'b1;
                    stall       = x_dm_en_i;
                end else if (x_dm_en_i) begin
                    if (x_dm_wen_i) begin
                        stall   = 1'b1;
                        state_d = WRITE;
                    end else if (hit) begin
                        load_hit = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        miss_start = 1'b1;
                        state_d    = REFILL_REQ;
                    end
                end
            end
            REFILL_REQ: begin
                stall     = 1'b1;
                dm_en_o   = 1'b1;
                dm_addr_o = line_base | (32'(cnt_q) << 2);
                if (!dm_busy_i) state_d = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                stall = 1'b1;
                if (dm_rvalid_i) begin
                    refill_beat = 1'b1;
                    state_d     = refill_last ? IDLE : REFILL_REQ;
                end
            end
            WRITE: begin
                stall     = 1'b1;
                dm_en_o   = 1'b1;
                dm_wen_o  = 1'b1;
                dm_addr_o = {x_dm_addr_i[31:2], 2'b00};
                dm_din_o  = x_dm_din_i;
                dm_be_o   = x_dm_be_i;
                if (!dm_busy_i) begin
                    store_merge = hit;
                    state_d     = WDONE;
                end
            end
            WDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dcache_stall_o = stall & ~rst_i;

    // Control state, valid bits, load data and counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
            cnt_q           <= '0;
            m_dm_dout_o     <= '0;
            load_cnt_o      <= '0;
            miss_cnt_o      <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i)          flush_pending_q <= 1'b1;
            else if (flush_apply) flush_pending_q <= 1'b0;
            if (flush_apply) valid_q <= '0;
            if (miss_start) begin
                // Line is invalid for the whole refill so a partial line never hits.
                valid_q[req_idx] <= 1'b0;
                cnt_q            <= '0;
                if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
            end
            if (refill_beat) begin
                if (refill_last) valid_q[req_idx] <= 1'b1;
                else             cnt_q            <= cnt_q + CW'(1);
            end
            if (load_hit) begin
                m_dm_dout_o <= data_q[word_idx];
                if (load_cnt_o != '1) load_cnt_o <= load_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

    // Tag and data storage; contents are qualified by valid_q so need no reset.
    always_ff @(posedge clk_i) begin
        if (refill_beat) begin
            data_q[fill_idx] <= dm_dout_i;
            if (refill_last) tag_q[req_idx] <= req_tag;
        end
        if (store_merge) begin
            for (int b = 0; b < 4; b++) begin
                if (x_dm_be_i[b]) data_q[word_idx][8*b +: 8] <= x_dm_din_i[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
module tb_dcache_dm;

    localparam int unsigned LINES = 16;
    localparam int unsigned WPL   = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        x_dm_en_i, x_dm_wen_i, flush_i;
    logic [31:0] x_dm_addr_i, x_dm_din_i;
    logic [3:0]  x_dm_be_i;
    logic [31:0] m_dm_dout_o;
    logic        dcache_stall_o, dm_en_o, dm_wen_o;
    logic [31:0] dm_addr_o, dm_din_o;
    logic [3:0]  dm_be_o;
    logic        dm_busy_i   = 1'b0;
    logic        dm_rvalid_i = 1'b0;
    logic [31:0] dm_dout_i   = '0;
    logic [15:0] load_cnt_o, miss_cnt_o;

    // Second instance: two single-word lines, 2-bit counters.
    logic        s_en, s_wen, s_flush, s_stall, s_dm_en, s_dm_wen;
    logic [31:0] s_addr, s_din, s_dout, s_dm_addr, s_dm_din;
    logic [3:0]  s_be, s_dm_be;
    logic        s_busy   = 1'b0;
    logic        s_rvalid = 1'b0;
    logic [31:0] s_rdata  = '0;
    logic [1:0]  s_load_cnt, s_miss_cnt;
    bit          s_pend   = 1'b0;
    logic [31:0] s_pend_addr = '0;

    always #5 clk_i = ~clk_i;

    dcache_dm u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_dm_en_i(x_dm_en_i), .x_dm_wen_i(x_dm_wen_i), .x_dm_addr_i(x_dm_addr_i),
        .x_dm_din_i(x_dm_din_i), .x_dm_be_i(x_dm_be_i), .flush_i(flush_i),
        .m_dm_dout_o(m_dm_dout_o), .dcache_stall_o(dcache_stall_o),
        .dm_en_o(dm_en_o), .dm_wen_o(dm_wen_o), .dm_addr_o(dm_addr_o),
        .dm_din_o(dm_din_o), .dm_be_o(dm_be_o), .dm_busy_i(dm_busy_i),
        .dm_rvalid_i(dm_rvalid_i), .dm_dout_i(dm_dout_i),
        .load_cnt_o(load_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    dcache_dm #(.LINES(2), .WORDS_PER_LINE(1), .CNT_WIDTH(2)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_dm_en_i(s_en), .x_dm_wen_i(s_wen), .x_dm_addr_i(s_addr),
        .x_dm_din_i(s_din), .x_dm_be_i(s_be), .flush_i(s_flush),
        .m_dm_dout_o(s_dout), .dcache_stall_o(s_stall),
        .dm_en_o(s_dm_en), .dm_wen_o(s_dm_wen), .dm_addr_o(s_dm_addr),
        .dm_din_o(s_dm_din), .dm_be_o(s_dm_be), .dm_busy_i(s_busy),
        .dm_rvalid_i(s_rvalid), .dm_dout_i(s_rdata),
        .load_cnt_o(s_load_cnt), .miss_cnt_o(s_miss_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing memory (written from the DUT port) and reference memory (written
    // from core-level stores); both start from the same address-derived pattern.
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Memory responder state.
    bit          rd_pend = 1'b0;
    int          rd_wait = 0;
    logic [31:0] rd_data = '0;
    logic [31:0] rd_addrs[$];
    bit          busy_force = 1'b0;
    bit          busy_rand  = 1'b0;
    int          mem_lat    = 2;
    int          wr_cnt     = 0;
    logic [31:0] exp_wr_addr = '0, exp_wr_din = '0;
    logic [3:0]  exp_wr_be   = '0;

    always @(negedge clk_i) begin
        logic [31:0] w;
        #2;
        dm_rvalid_i = 1'b0;
        if (rd_pend) begin
            if (rd_wait == 0) begin
                dm_rvalid_i = 1'b1;
                dm_dout_i   = rd_data;
                rd_pend     = 1'b0;
            end else begin
                rd_wait--;
            end
        end
        dm_busy_i = busy_force || (busy_rand && ($urandom_range(0, 3) == 0));
        if (dm_en_o && !dm_busy_i) begin
            if (dm_wen_o) begin
                wr_cnt++;
                check("wr_addr", dm_addr_o, exp_wr_addr);
                check("wr_din", dm_din_o, exp_wr_din);
                check("wr_be", 32'(dm_be_o), 32'(exp_wr_be));
                w = mem_rd(dm_addr_o);
                for (int b = 0; b < 4; b++)
                    if (dm_be_o[b]) w[8*b +: 8] = dm_din_o[8*b +: 8];
                mem[dm_addr_o] = w;
            end else begin
                rd_pend = 1'b1;
                rd_wait = (mem_lat > 0) ? mem_lat - 1 : int'($urandom_range(0, 2));
                rd_data = mem_rd(dm_addr_o);
                rd_addrs.push_back(dm_addr_o);
            end
        end
    end

    // Single-cycle-latency memory for the small instance.
    always @(negedge clk_i) begin
        #2;
        s_rvalid    = s_pend;
        s_rdata     = s_pend_addr ^ 32'h0F0F_0000;
        s_pend      = s_dm_en && !s_dm_wen;
        s_pend_addr = s_dm_addr;
    end

    // Reference cache-contents model and expected counters.
    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];
    int          exp_load = 0;
    int          exp_miss = 0;
    logic [31:0] last_load = '0;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) & 32'(LINES - 1));
    endfunction

    task automatic check_counters();
        check("load_cnt", 32'(load_cnt_o), 32'(exp_load));
        check("miss_cnt", 32'(miss_cnt_o), 32'(exp_miss));
    endtask

    task automatic do_load(input logic [31:0] a);
        int idx, cyc;
        bit hit;
        logic [31:0] base;
        idx  = line_of(a);
        base = a & ~32'hF;
        hit  = mvalid[idx] && (mtag[idx] == (a >> 8));
        @(negedge clk_i);
        rd_addrs.delete();
        x_dm_en_i = 1'b1; x_dm_wen_i = 1'b0; x_dm_addr_i = a;
        #1;
        cyc = 0;
        while (dcache_stall_o && cyc < 500) begin
            @(negedge clk_i); #1; cyc++;
        end
        if (cyc >= 500) check("load_timeout", 32'd1, 32'd0);
        check("load_hit", 32'(cyc == 0), 32'(hit));
        if (!hit) begin
            exp_miss++;
            check("refill_beats", 32'(rd_addrs.size()), 32'(WPL));
            if (rd_addrs.size() == WPL)
                for (int i = 0; i < WPL; i++) check("refill_addr", rd_addrs[i], base + 32'(4 * i));
            mvalid[idx] = 1'b1;
            mtag[idx]   = a >> 8;
        end
        @(posedge clk_i);
        exp_load++;
        @(negedge clk_i);
        x_dm_en_i = 1'b0;
        last_load = ref_rd(a & ~32'h3);
        #1;
        check("load_data", m_dm_dout_o, last_load);
        check_counters();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int cyc, w0;
        logic [31:0] w;
        @(negedge clk_i);
        exp_wr_addr = a & ~32'h3; exp_wr_din = d; exp_wr_be = be;
        w0 = wr_cnt;
        x_dm_en_i = 1'b1; x_dm_wen_i = 1'b1; x_dm_addr_i = a; x_dm_din_i = d; x_dm_be_i = be;
        #1;
        cyc = 0;
        while (dcache_stall_o && cyc < 500) begin
            @(negedge clk_i); #1; cyc++;
        end
        if (cyc >= 500) check("store_timeout", 32'd1, 32'd0);
        check("store_stall", 32'(cyc >= 2), 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        x_dm_en_i = 1'b0;
        #1;
        check("store_writes", 32'(wr_cnt - w0), 32'd1);
        check("store_keeps_dout", m_dm_dout_o, last_load);
        check_counters();
        w = ref_rd(a & ~32'h3);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a & ~32'h3] = w;
    endtask

    task automatic do_flush();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, w;
        int cyc, r;
        x_dm_en_i = 0; x_dm_wen_i = 0; x_dm_addr_i = 0; x_dm_din_i = 0; x_dm_be_i = 0; flush_i = 0;
        s_en = 0; s_wen = 0; s_addr = 0; s_din = 0; s_be = 0; s_flush = 0;
        for (int i = 0; i < LINES; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        #2;
        check("rst_stall", 32'(dcache_stall_o), 32'd0);
        check("rst_dm_en", 32'(dm_en_o), 32'd0);
        check("rst_dout", m_dm_dout_o, 32'd0);
        check("rst_load_cnt", 32'(load_cnt_o), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
        check("rst_s_cnt", 32'(s_load_cnt), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Cold miss then hit.
        mem_lat = 2;
        do_load(32'h100);
        check("cold_data", m_dm_dout_o, init_word(32'h100));
        do_load(32'h108);

        // Store hit with partial byte enables, then reload.
        do_store(32'h104, 32'hAABB_CCDD, 4'b0011);
        do_load(32'h104);
        w = init_word(32'h104);
        check("merge_data", m_dm_dout_o, {w[31:16], 16'hCCDD});

        // Store miss does not allocate; original line still hits.
        do_store(32'h400, 32'h1122_3344, 4'b1111);
        do_load(32'h100);

        // Conflict eviction.
        do_load(32'h500);
        do_load(32'h100);

        // Busy during refill request, then flush mid-refill.
        @(negedge clk_i);
        rd_addrs.delete();
        busy_force = 1'b1;
        x_dm_en_i = 1'b1; x_dm_wen_i = 1'b0; x_dm_addr_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); #1;
            check("busy_en_held", 32'(dm_en_o), 32'd1);
            check("busy_addr_held", dm_addr_o, 32'h200);
        end
        busy_force = 1'b0;
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        cyc = 0;
        while (dcache_stall_o && cyc < 500) begin
            @(negedge clk_i); #1; cyc++;
        end
        if (cyc >= 500) check("flush_timeout", 32'd1, 32'd0);
        check("flush_refetch_beats", 32'(rd_addrs.size()), 32'(2 * WPL));
        @(posedge clk_i);
        exp_load++;
        exp_miss += 2;
        @(negedge clk_i);
        x_dm_en_i = 1'b0;
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        mvalid[0] = 1'b1; mtag[0] = 32'h2;
        last_load = ref_rd(32'h200);
        #1;
        check("flush_load_data", m_dm_dout_o, last_load);
        check_counters();
        do_load(32'h100);

        // Reset while a refill read is outstanding.
        mem_lat = 3;
        @(negedge clk_i);
        x_dm_en_i = 1'b1; x_dm_wen_i = 1'b0; x_dm_addr_i = 32'h300;
        cyc = 0;
        while (!rd_pend && cyc < 50) begin
            @(negedge clk_i); #3; cyc++;
        end
        if (cyc >= 50) check("refill_start_timeout", 32'd1, 32'd0);
        @(negedge clk_i); #3;
        rst_i = 1'b1;
        x_dm_en_i = 1'b0;
        #1;
        check("midrst_stall", 32'(dcache_stall_o), 32'd0);
        check("midrst_dm_en", 32'(dm_en_o), 32'd0);
        check("midrst_dm_addr", dm_addr_o, 32'd0);
        check("midrst_dout", m_dm_dout_o, 32'd0);
        check("midrst_load_cnt", 32'(load_cnt_o), 32'd0);
        check("midrst_miss_cnt", 32'(miss_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_load = 0; exp_miss = 0; last_load = '0;
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        cyc = 0;
        while (rd_pend && cyc < 20) begin
            @(negedge clk_i); #3; cyc++;
        end
        @(negedge clk_i); #1;
        check("late_rvalid_idle", 32'(dcache_stall_o), 32'd0);
        check("late_rvalid_dout", m_dm_dout_o, 32'd0);
        do_load(32'h300);

        // Randomised traffic with memory back-pressure and variable latency.
        mem_lat = 0;
        busy_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4)
              | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if (r < 6)      do_load(a);
            else if (r < 9) do_store(a, $urandom, 4'($urandom_range(0, 15)));
            else            do_flush();
        end
        busy_rand = 1'b0;

        // Counter saturation on the 2-bit instance: one miss, four hits.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            s_en = 1'b1; s_addr = 32'h40;
            #1;
            cyc = 0;
            while (s_stall && cyc < 100) begin
                @(negedge clk_i); #1; cyc++;
            end
            if (cyc >= 100) check("sat_timeout", 32'd1, 32'd0);
            @(posedge clk_i);
            @(negedge clk_i);
            s_en = 1'b0;
            #1;
            check("sat_data", s_dout, 32'h40 ^ 32'h0F0F_0000);
        end
        check("sat_load_cnt", 32'(s_load_cnt), 32'd3);
        check("sat_miss_cnt", 32'(s_miss_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache between the core's X/M memory stage and the single-word data-memory port.
- Successor to the current pass-through data path: adds configurable line count and line size, byte-enabled stores, full invalidate, and performance counters.
- Lookup happens in X; load data is registered into M; misses and stores stall the pipeline via `dcache_stall_o`.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥1).
- CNT_WIDTH, 16, width of the saturating performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- x_dm_en_i  in  1  memory request valid in X.
- x_dm_wen_i  in  1  1 = store, 0 = load.
- x_dm_addr_i  in  32  byte address; bits [1:0] are ignored.
- x_dm_din_i  in  32  store data.
- x_dm_be_i  in  4  store byte enables.
- flush_i  in  1  invalidate all lines.
- m_dm_dout_o  out  32  load data for M stage.
- dcache_stall_o  out  1  pipeline stall.
- dm_en_o  out  1  memory request.
- dm_wen_o  out  1  memory write.
- dm_addr_o  out  32  word-aligned memory address.
- dm_din_o  out  32  memory write data.
- dm_be_o  out  4  memory byte enables.
- dm_busy_i  in  1  memory cannot accept a request this cycle.
- dm_rvalid_i  in  1  read data valid on dm_dout_i.
- dm_dout_i  in  32  memory read data.
- load_cnt_o  out  CNT_WIDTH  loads consumed.
- miss_cnt_o  out  CNT_WIDTH  refills started.

Behaviour:
- **Clock and reset.** Single clock domain. Asynchronous active-high reset.
  - On reset: all valid bits = 0, state = IDLE, flush_pending = 0.
  - All outputs reset to 0, including counters and m_dm_dout_o.
- **Address split.**
  - OFF = log2(WORDS_PER_LINE); IDX = log2(LINES).
  - Word offset = addr[2+OFF-1:2]; index = addr[2+OFF+IDX-1:2+OFF]; tag = the remaining upper bits.
  - Tag, valid and data arrays are flops, read combinationally.
- **Request protocol.**
  - Core holds all x_* inputs stable while dcache_stall_o=1.
  - A request present in a cycle with dcache_stall_o=0 is consumed at that clock edge.
  - dcache_stall_o is combinational.
- **Memory handshake.**
  - A request is accepted at an edge where dm_en_o=1 and dm_busy_i=0.
  - dm_en_o, dm_addr_o, dm_wen_o, dm_din_o and dm_be_o are held until accepted.
  - At most one read outstanding. Read data returns with dm_rvalid_i at least 1 cycle after acceptance.
- **State IDLE.**
  - Load hit: stall=0; m_dm_dout_o <= cached word at the edge; load_cnt++.
  - Load miss: stall=1; next state REFILL_REQ; miss_cnt++; word counter <= 0.
  - Store: stall=1; next state WRITE.
  - No request: m_dm_dout_o holds its value.
- **State REFILL_REQ.**
  - stall=1; dm_en_o=1, dm_wen_o=0.
  - dm_addr_o = {tag, index, word counter, 2'b00}.
  - On acceptance, next state REFILL_WAIT.
- **State REFILL_WAIT.**
  - stall=1. On dm_rvalid_i, write dm_dout_i into data[index][counter].
  - If counter == WORDS_PER_LINE-1: set tag[index] and valid[index], next state IDLE.
  - Otherwise: counter++, next state REFILL_REQ.
  - Valid is cleared at REFILL_REQ entry, so a partial line is never hit.
  - The held load then hits in IDLE and is consumed. Miss penalty = refill time + 1 cycle.
- **State WRITE.**
  - stall=1; dm_en_o=1, dm_wen_o=1; dm_addr_o = addr word-aligned; dm_din_o = x_dm_din_i; dm_be_o = x_dm_be_i.
  - On acceptance: if the line hits, merge the enabled bytes into the cached word. A miss does not allocate. Next state WDONE.
- **State WDONE.**
  - stall=0; the held store is consumed; next state IDLE.
  - Stores do not change m_dm_dout_o or counters.
- **Flush.**
  - flush_i sets flush_pending in any state.
  - flush_pending is applied only in IDLE: all valid bits are cleared at that edge and flush_pending is cleared.
  - Any request that cycle sees stall=1 and is re-evaluated next cycle; flush takes priority over lookup.
- **Counters.** Counters saturate at all-ones and do not wrap.
- **Degenerate case.** WORDS_PER_LINE=1 gives single-beat refills; OFF is zero-width and the offset field is omitted.
- **Reset mid-operation.**
  - The outstanding memory read is abandoned; a dm_rvalid_i arriving after reset is ignored in IDLE.
  - Partially filled lines remain invalid.

Test Plan:
1. **Cold miss then hit.** Defaults, memory with 2-cycle rvalid latency. Load 0x100 with no busy → stall for 4 words; dm_addr_o sequence 0x100, 0x104, 0x108, 0x10C; then load consumed, m_dm_dout_o = mem[0x100]; load_cnt=1, miss_cnt=1. A following load of 0x108 hits with no stall, data = mem[0x108], load_cnt=2.
2. **Store hit with byte enables.** After test 1, store 0x104 with din=0xAABBCCDD, be=4'b0011 → exactly one write request, dm_be_o=0011, stall for ≥2 cycles. A reload of 0x104 hits and returns the upper 16 bits of the old data with low half 0xCCDD.
3. **Store miss.** Store 0x400 → one memory write; valid for index 0 is unchanged. Reload of 0x100 still hits.
4. **Conflict eviction.** Load 0x100, then load 0x500 (same index, different tag) → second refill, miss_cnt=2. Reload of 0x100 misses again.
5. **Busy and flush during refill.** Hold dm_busy_i=1 for 3 cycles during REFILL_REQ → dm_en_o and dm_addr_o stay stable. Pulse flush_i mid-refill → refill completes, the flush is applied in IDLE with stall=1, and the held load misses again.
6. **Reset mid-refill, saturation.** Assert rst_i during REFILL_WAIT → all outputs 0, stall=0, a late dm_rvalid_i is ignored, and the next load misses. Separately, with CNT_WIDTH=2, consume 5 load hits → load_cnt_o = 3.
